multi_config_d_flip_flop: RTL and testbench



---
 rtl/multi_config_d_flip_flop.sv | 94 +++++++++
 tb/tb_multi_config_d_flip_flop.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_config_d_flip_flop.sv
// Configurable D register: capture edge, secondary-reset type and secondary-reset
// polarity are all fixed at elaboration by a 3-bit code. A master asynchronous
// active-high reset is always present and has highest priority.
//
// CFG bit map: [1] edge (0 pos, 1 neg), [2] srst type (0 sync, 1 async),
//              [0] srst polarity (0 active-high, 1 active-low).
module multi_config_d_flip_flop #(
    parameter int unsigned            CFG     = 0,
    parameter int unsigned            WIDTH   = 1,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] out,
    input  logic             srst,
    output logic [2:0]       cfg_o
);

    localparam logic [2:0] CfgBits   = 3'(CFG);
    localparam bit         ActiveLow = CfgBits[0];
    localparam bit         NegEdge   = CfgBits[1];
    localparam bit         AsyncSrst = CfgBits[2];

    // Reject codes and widths outside the supported range at elaboration.
    if (CFG > 7) begin : g_bad_cfg
        $error("multi_config_d_flip_flop: CFG must be in 0..7");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("multi_config_d_flip_flop: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] out_q;
    logic             srst_act;

    // Normalise srst to active-high so every variant below tests one polarity.
    always_comb begin
        srst_act = ActiveLow ? ~srst : srst;
    end

    // Exactly one of the four register variants is elaborated.
    if (!AsyncSrst && !NegEdge) begin : g_pos_sync
        // Rising-edge capture, srst only sampled on the capture edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= RST_VAL;
            end else if (srst_act) begin
                out_q <= RST_VAL;
            end else begin
                out_q <= d;
            end
        end
    end else if (!AsyncSrst && NegEdge) begin : g_neg_sync
        // Falling-edge capture, srst only sampled on the capture edge.
        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                out_q <= RST_VAL;
            end else if (srst_act) begin
                out_q <= RST_VAL;
            end else begin
                out_q <= d;
            end
        end
    end else if (AsyncSrst && !NegEdge) begin : g_pos_async
        // Rising-edge capture; srst clears immediately and holds while asserted.
        always_ff @(posedge clk or posedge rst or posedge srst_act) begin
            if (rst) begin
                out_q <= RST_VAL;
            end else if (srst_act) begin
                out_q <= RST_VAL;
            end else begin
                out_q <= d;
            end
        end
    end else begin : g_neg_async
        // Falling-edge capture; srst clears immediately and holds while asserted.
        always_ff @(negedge clk or posedge rst or posedge srst_act) begin
            if (rst) begin
                out_q <= RST_VAL;
            end else if (srst_act) begin
                out_q <= RST_VAL;
            end else begin
                out_q <= d;
            end
        end
    end

    // Drive outputs: registered data and the constant configuration code.
    always_comb begin
        out   = out_q;
        cfg_o = CfgBits;
    end

endmodule

// File: tb/tb_multi_config_d_flip_flop.sv
// Directed bench for multi_config_d_flip_flop: all eight 1-bit variants plus one
// 8-bit variant (CFG=5, RST_VAL=8'hA5) share clock, data and master reset.
module tb_multi_config_d_flip_flop;

    localparam int NumInst = 9;

    typedef struct {
        int         idx;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [7:0]       d8;
    logic             srst_on;
    logic [NumInst-1:0] srst_v;
    logic [7:0]       out_nb;
    logic [7:0]       out_w;
    logic [2:0]       cfgo [NumInst];

    logic [7:0]       model [NumInst];
    exp_t             sb [$];
    int               checks = 0;
    int               errors = 0;

    function automatic int unsigned cfg_of(input int i);
        return (i == 8) ? 5 : i;
    endfunction

    function automatic logic [7:0] rv(input int i);
        return (i == 8) ? 8'hA5 : 8'h00;
    endfunction

    function automatic logic [7:0] dv(input int i);
        return (i == 8) ? d8 : {7'b0, d8[0]};
    endfunction

    function automatic logic [7:0] obs(input int i);
        return (i == 8) ? out_w : {7'b0, out_nb[i]};
    endfunction

    // Per-instance srst level: active-low variants see the inverted request.
    always_comb begin
        srst_v = '0;
        for (int i = 0; i < NumInst; i++) begin
            srst_v[i] = ((cfg_of(i) & 1) != 0) ? ~srst_on : srst_on;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_dut
        multi_config_d_flip_flop #(
            .CFG    (g),
            .WIDTH  (1),
            .RST_VAL(1'b0)
        ) u_dut (
            .rst  (rst),
            .clk  (clk),
            .d    (d8[0]),
            .out  (out_nb[g]),
            .srst (srst_v[g]),
            .cfg_o(cfgo[g])
        );
    end

    multi_config_d_flip_flop #(
        .CFG    (5),
        .WIDTH  (8),
        .RST_VAL(8'hA5)
    ) u_dut_wide (
        .rst  (rst),
        .clk  (clk),
        .d    (d8),
        .out  (out_w),
        .srst (srst_v[8]),
        .cfg_o(cfgo[8])
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, required finish before 50000");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        for (int i = 0; i < NumInst; i++) model[i] = rv(i);
    endfunction

    function automatic void model_srst_async();
        for (int i = 0; i < NumInst; i++) begin
            if ((cfg_of(i) & 4) != 0) model[i] = rv(i);
        end
    endfunction

    function automatic void model_edge(input logic rising);
        bit neg;
        for (int i = 0; i < NumInst; i++) begin
            neg = ((cfg_of(i) & 2) != 0);
            if ((rising && !neg) || (!rising && neg)) begin
                model[i] = (rst || srst_on) ? rv(i) : dv(i);
            end
        end
    endfunction

    // Queue expected outputs of every instance, then pop and compare them.
    task automatic check(input string tag);
        exp_t it;
        for (int i = 0; i < NumInst; i++) sb.push_back('{idx: i, exp: model[i], tag: tag});
        while (sb.size() > 0) begin
            it = sb.pop_front();
            checks++;
            assert (obs(it.idx) === it.exp) else begin
                errors++;
                $error("FAIL %s[%0d]: observed %h expected %h", it.tag, it.idx,
                       obs(it.idx), it.exp);
            end
        end
    endtask

    task automatic check_cfg(input string tag);
        logic [2:0] want;
        for (int i = 0; i < NumInst; i++) begin
            want = 3'(cfg_of(i));
            checks++;
            assert (cfgo[i] === want) else begin
                errors++;
                $error("FAIL %s[%0d]: observed %0d expected %0d", tag, i, cfgo[i], want);
            end
        end
    endtask

    task automatic next_edge(input string tag);
        @(clk);
        #1;
        model_edge(clk);
        check(tag);
    endtask

    initial begin
        rst     = 1'b1;
        srst_on = 1'b0;
        d8      = 8'h00;
        #1;
        model_reset();
        check("reset");
        check_cfg("cfg_t0");

        // Active edge while rst is held must not capture.
        d8 = 8'h3C;
        @(posedge clk);
        #1;
        check("rst_hold_edge");
        check_cfg("cfg_in_rst");
        #4 rst = 1'b0;
        #1 check("rst_release_hold");

        // Free run: random data changed mid-phase, compared after every edge
        // and again between edges.
        for (int k = 0; k < 10; k++) begin
            next_edge("run_edge");
            #4 d8 = 8'($urandom);
            #1 check("run_no_edge");
        end

        // Bring every output to its all-ones state.
        d8 = 8'hFF;
        next_edge("fill");
        next_edge("fill");
        if (!clk) next_edge("fill");

        // Master reset pulse of 6 units mid-cycle.
        #1 rst = 1'b1;
        model_reset();
        #1 check("rst_async");
        #5 rst = 1'b0;
        #1 check("rst_pulse_release");
        next_edge("rst_recover");
        next_edge("rst_recover");

        // srst for 4 units, no edge inside the window.
        #2 srst_on = 1'b1;
        model_srst_async();
        #1 check("srst_mid_assert");
        #3 srst_on = 1'b0;
        #1 check("srst_mid_release");
        next_edge("srst_mid_recover");
        next_edge("srst_mid_recover");

        // srst for 4 units spanning a rising edge.
        #17 srst_on = 1'b1;
        model_srst_async();
        #1 check("srst_rise_assert");
        next_edge("srst_rise_edge");
        #1 srst_on = 1'b0;
        #1 check("srst_rise_release");
        next_edge("srst_rise_recover");
        next_edge("srst_rise_recover");

        // srst for 4 units spanning a falling edge.
        #7 srst_on = 1'b1;
        model_srst_async();
        #1 check("srst_fall_assert");
        next_edge("srst_fall_edge");
        #1 srst_on = 1'b0;
        #1 check("srst_fall_release");
        next_edge("srst_fall_recover");
        next_edge("srst_fall_recover");

        // rst asserted on the same timestep as a rising edge: reset wins.
        @(posedge clk);
        rst = 1'b1;
        model_reset();
        #1 check("rst_coincident");
        check_cfg("cfg_in_rst2");
        #3 rst = 1'b0;
        next_edge("final");
        next_edge("final");
        check_cfg("cfg_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
